down_timer: RTL and testbench

- Loadable down-counting timer. It is the counting-down counterpart of the team's up counter.
- Holds a reload value, counts down on enabled cycles, and flags the terminal count.
- Supports one-shot and auto-reload modes.
- Used as a period/timeout generator beside the up-counter datapaths; bo gives a combinational terminal strobe for chaining.

---
 rtl/down_timer.sv | 113 +++++++++++
 tb/tb_down_timer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
`default_nettype none
// ============================================================================
//  Module   : down_timer
//  Function : Loadable down-counting timer with one-shot / auto-reload modes,
//             registered done pulse and combinational borrow-out for chaining.
//             Optional prescaler compiled in with DOWN_TIMER_PRESCALE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ld,
    input  logic             start,
    input  logic             stop,
    input  logic             cen,
    input  logic             auto_reload,
`ifdef DOWN_TIMER_PRESCALE_EN
    input  logic [7:0]       presc,
`endif
    output logic [WIDTH-1:0] par_out,
    output logic             busy,
    output logic             expired,
    output logic             done,
    output logic             bo
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             done_q;

    logic w_tick;
    logic w_dec;
    logic w_term;

`ifdef DOWN_TIMER_PRESCALE_EN
    logic [7:0] presc_q;

    assign w_tick = (presc_q == presc);

    // Restarted by any control action so each run begins a full prescale period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= 8'd0;
        end else if (ld || start || stop) begin
            presc_q <= 8'd0;
        end else if ((state_q == ST_RUN) && cen) begin
            presc_q <= w_tick ? 8'd0 : presc_q + 8'd1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    assign w_dec  = (state_q == ST_RUN) && cen && w_tick;
    assign w_term = w_dec && (count_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ld) begin
                reload_q <= par_in;
                count_q  <= par_in;
                state_q  <= ST_IDLE;
            end else if (stop) begin
                if (state_q == ST_RUN) begin
                    state_q <= ST_IDLE;
                end
            end else if (start && (state_q != ST_RUN)) begin
                // Resume from IDLE keeps the paused count; from EXPIRED re-arm.
                if (state_q == ST_EXPIRED) begin
                    count_q <= reload_q;
                end
                state_q <= ST_RUN;
            end else if (w_dec) begin
                if (count_q == '0) begin
                    done_q <= 1'b1;
                    if (auto_reload) begin
                        count_q <= reload_q;
                    end else begin
                        state_q <= ST_EXPIRED;
                    end
                end else begin
                    count_q <= count_q - C_ONE;
                end
            end
        end
    end

    assign par_out = count_q;
    assign busy    = (state_q == ST_RUN);
    assign expired = (state_q == ST_EXPIRED);
    assign done    = done_q;
    assign bo      = w_term;

endmodule
`default_nettype wire

// File: tb/tb_down_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_down_timer
//  Function : Directed self-checking bench for down_timer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_down_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] par_in = 8'd0;
    logic       ld = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cen = 1'b0;
    logic       auto_reload = 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
    logic [7:0] presc = 8'd0;
`endif
    logic [7:0] par_out;
    logic       busy;
    logic       expired;
    logic       done;
    logic       bo;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [11:0] exp_v;
    wire  [11:0] obs = {par_out, busy, expired, done, bo};

    down_timer #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .par_in      (par_in),
        .ld          (ld),
        .start       (start),
        .stop        (stop),
        .cen         (cen),
        .auto_reload (auto_reload),
`ifdef DOWN_TIMER_PRESCALE_EN
        .presc       (presc),
`endif
        .par_out     (par_out),
        .busy        (busy),
        .expired     (expired),
        .done        (done),
        .bo          (bo)
    );

    always #5 clk = ~clk;

    // obs layout: {par_out[7:0], busy, expired, done, bo}
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        par_in = v;
        ld     = 1'b1;
        step();
        ld     = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (obs !== 12'h000) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", obs, 12'h000);
        end
        #3 rst = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        auto_reload = 1'b0;
        cen = 1'b0;
        load(8'd5);
        kick();
        n_cmp++;
        if (obs !== {8'd5, 4'b1000}) begin
            n_fail++; $display("FAIL async_pre: got %h expected %h", obs, {8'd5, 4'b1000});
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 12'h000) begin
            n_fail++; $display("FAIL async_reset: got %h expected %h", obs, 12'h000);
        end
        #1 rst = 1'b0;
        step();
        // reload must be cleared: a terminal event in auto-reload reloads 0
        auto_reload = 1'b1;
        kick();
        cen = 1'b1;
        #1;
        n_cmp++;
        if (obs !== {8'd0, 4'b1001}) begin
            n_fail++; $display("FAIL async_reload_bo: got %h expected %h", obs, {8'd0, 4'b1001});
        end
        step();
        n_cmp++;
        if (obs !== {8'd0, 4'b1011}) begin
            n_fail++; $display("FAIL async_reload_cleared: got %h expected %h", obs, {8'd0, 4'b1011});
        end
        cen = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_one_shot();
        auto_reload = 1'b0;
        cen = 1'b0;
        load(8'd3);
        n_cmp++;
        if (obs !== {8'd3, 4'b0000}) begin
            n_fail++; $display("FAIL oneshot_load: got %h expected %h", obs, {8'd3, 4'b0000});
        end
        cen = 1'b1;
        kick();
        n_cmp++;
        if (obs !== {8'd3, 4'b1000}) begin
            n_fail++; $display("FAIL oneshot_start: got %h expected %h", obs, {8'd3, 4'b1000});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = {8'(2 - i), 1'b1, 1'b0, 1'b0, (i == 2)};
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL oneshot_count[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        step();
        n_cmp++;
        if (obs !== {8'd0, 4'b0110}) begin
            n_fail++; $display("FAIL oneshot_done: got %h expected %h", obs, {8'd0, 4'b0110});
        end
        step();
        n_cmp++;
        if (obs !== {8'd0, 4'b0100}) begin
            n_fail++; $display("FAIL oneshot_hold: got %h expected %h", obs, {8'd0, 4'b0100});
        end
    endtask

    task automatic test_auto_reload();
        auto_reload = 1'b1;
        cen = 1'b1;
        load(8'd2);
        kick();
        for (int i = 0; i < 9; i++) begin
            exp_v = {8'(2 - (i % 3)), 1'b1, 1'b0, (i > 0) && (i % 3 == 0), (i % 3 == 2)};
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL autoreload[%0d]: got %h expected %h", i, obs, exp_v);
            end
            step();
        end
        cen = 1'b0;
    endtask

    task automatic test_pause_resume();
        auto_reload = 1'b0;
        cen = 1'b1;
        load(8'd6);
        kick();
        step();
        step();
        n_cmp++;
        if (obs !== {8'd4, 4'b1000}) begin
            n_fail++; $display("FAIL pause_before: got %h expected %h", obs, {8'd4, 4'b1000});
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_cmp++;
        if (obs !== {8'd4, 4'b0000}) begin
            n_fail++; $display("FAIL pause_stop: got %h expected %h", obs, {8'd4, 4'b0000});
        end
        step();
        n_cmp++;
        if (obs !== {8'd4, 4'b0000}) begin
            n_fail++; $display("FAIL pause_hold: got %h expected %h", obs, {8'd4, 4'b0000});
        end
        kick();
        n_cmp++;
        if (obs !== {8'd4, 4'b1000}) begin
            n_fail++; $display("FAIL pause_resume: got %h expected %h", obs, {8'd4, 4'b1000});
        end
        step();
        step();
        n_cmp++;
        if (obs !== {8'd2, 4'b1000}) begin
            n_fail++; $display("FAIL pause_continue: got %h expected %h", obs, {8'd2, 4'b1000});
        end
    endtask

    task automatic test_ld_collision();
        auto_reload = 1'b0;
        cen = 1'b1;
        load(8'd1);
        kick();
        step();
        n_cmp++;
        if (obs !== {8'd0, 4'b1001}) begin
            n_fail++; $display("FAIL ldcol_pre: got %h expected %h", obs, {8'd0, 4'b1001});
        end
        load(8'd9);
        n_cmp++;
        if (obs !== {8'd9, 4'b0000}) begin
            n_fail++; $display("FAIL ldcol_load: got %h expected %h", obs, {8'd9, 4'b0000});
        end
        step();
        n_cmp++;
        if (obs !== {8'd9, 4'b0000}) begin
            n_fail++; $display("FAIL ldcol_nodone: got %h expected %h", obs, {8'd9, 4'b0000});
        end
    endtask

    task automatic test_start_expired();
        auto_reload = 1'b0;
        cen = 1'b1;
        load(8'd2);
        kick();
        step();
        step();
        step();
        n_cmp++;
        if (obs !== {8'd0, 4'b0110}) begin
            n_fail++; $display("FAIL restart_expired: got %h expected %h", obs, {8'd0, 4'b0110});
        end
        par_in = 8'd7;
        kick();
        n_cmp++;
        if (obs !== {8'd2, 4'b1000}) begin
            n_fail++; $display("FAIL restart_reload: got %h expected %h", obs, {8'd2, 4'b1000});
        end
        step();
        n_cmp++;
        if (obs !== {8'd1, 4'b1000}) begin
            n_fail++; $display("FAIL restart_count: got %h expected %h", obs, {8'd1, 4'b1000});
        end
    endtask

    task automatic test_cen_toggle();
        auto_reload = 1'b0;
        cen = 1'b0;
        load(8'd4);
        kick();
        for (int i = 0; i < 6; i++) begin
            cen = (i % 2 == 0);
            step();
            exp_v = {8'(3 - i / 2), 4'b1000};
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL cen_toggle[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        cen = 1'b0;
    endtask

    task automatic test_zero_period();
        auto_reload = 1'b1;
        cen = 1'b1;
        load(8'd0);
        kick();
        for (int i = 0; i < 3; i++) begin
            exp_v = {8'd0, 1'b1, 1'b0, (i > 0), 1'b1};
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL zero_period[%0d]: got %h expected %h", i, obs, exp_v);
            end
            step();
        end
        cen = 1'b0;
    endtask

`ifdef DOWN_TIMER_PRESCALE_EN
    task automatic test_prescale();
        auto_reload = 1'b0;
        cen = 1'b1;
        presc = 8'd2;
        load(8'd1);
        kick();
        for (int i = 1; i <= 5; i++) begin
            step();
            exp_v = {(i < 3) ? 8'd1 : 8'd0, 1'b1, 1'b0, 1'b0, (i == 5)};
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL prescale[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        step();
        n_cmp++;
        if (obs !== {8'd0, 4'b0110}) begin
            n_fail++; $display("FAIL prescale_done: got %h expected %h", obs, {8'd0, 4'b0110});
        end
        presc = 8'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_async_reset();
        test_one_shot();
        test_auto_reload();
        test_pause_resume();
        test_ld_collision();
        test_start_expired();
        test_cen_toggle();
        test_zero_period();
`ifdef DOWN_TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
